flash_read_controller: RTL

// Responder side of the sample-fetch handshake. Accepts a word-address request from the

---
 rtl/flash_read_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/flash_read_controller.sv
// Flash read controller: accepts a word-address request from the sample
// address sequencer and performs one Avalon-MM single-word read of the flash
// controller, returning the word with a one-cycle valid pulse.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for a request edge or a buffered (pending) request
// ASSERT_READ | read strobe high, address held until the slave drops waitrequest
// WAIT_DATA   | read accepted, waiting for readdatavalid or the timeout
// DONE        | data_valid pulse for exactly one cycle
module flash_read_controller #(
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] address_in_i,
    output logic                  flash_mem_read_o,
    output logic [ADDR_WIDTH-1:0] flash_mem_address_o,
    output logic [3:0]            flash_mem_byteenable_o,
    input  logic                  flash_mem_waitrequest_i,
    input  logic [31:0]           flash_mem_readdata_i,
    input  logic                  flash_mem_readdatavalid_i,
    output logic [31:0]           data_out_o,
    output logic                  data_valid_o,
    output logic                  busy_o,
    output logic                  timeout_err_o
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_ASSERT_READ = 2'd1;
    localparam logic [1:0] S_WAIT_DATA   = 2'd2;
    localparam logic [1:0] S_DONE        = 2'd3;

    // Timer value on which WAIT_DATA gives up; legal TIMEOUT_CYCLES is 1..255.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q,        state_d;
    logic                  start_dly_q;
    logic                  pending_q,      pending_d;
    logic [ADDR_WIDTH-1:0] pending_addr_q, pending_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q,         addr_d;
    logic [7:0]            timer_q,        timer_d;
    logic [31:0]           data_out_q,     data_out_d;
    logic                  timeout_err_q,  timeout_err_d;
    logic                  req;

    assign req = start_i & ~start_dly_q;

    // Next-state logic: FSM, one-deep request buffer and WAIT_DATA timeout.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;
        addr_d         = addr_q;
        timer_d        = timer_q;
        data_out_d     = data_out_q;
        timeout_err_d  = timeout_err_q;

        // A request arriving while busy (DONE included) is buffered; the newest wins.
        if (req && (state_q != S_IDLE)) begin
            pending_d      = 1'b1;
            pending_addr_d = address_in_i;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d        = address_in_i;
                    pending_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_ASSERT_READ;
                end else if (pending_q) begin
                    addr_d        = pending_addr_q;
                    pending_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_ASSERT_READ;
                end
            end
            S_ASSERT_READ: begin
                if (!flash_mem_waitrequest_i) begin
                    timer_d = 8'd0;
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid_i) begin
                    data_out_d = flash_mem_readdata_i;
                    state_d    = S_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    data_out_d    = 32'd0;
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any read in flight and the buffered request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            start_dly_q    <= 1'b0;
            pending_q      <= 1'b0;
            pending_addr_q <= '0;
            addr_q         <= '0;
            timer_q        <= 8'd0;
            data_out_q     <= 32'd0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_dly_q    <= start_i;
            pending_q      <= pending_d;
            pending_addr_q <= pending_addr_d;
            addr_q         <= addr_d;
            timer_q        <= timer_d;
            data_out_q     <= data_out_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign flash_mem_read_o       = (state_q == S_ASSERT_READ);
    assign flash_mem_address_o    = addr_q;
    assign flash_mem_byteenable_o = flash_mem_read_o ? 4'b1111 : 4'b0000;
    assign data_out_o             = data_out_q;
    assign data_valid_o           = (state_q == S_DONE);
    assign busy_o                 = (state_q != S_IDLE);
    assign timeout_err_o          = timeout_err_q;

endmodule
